bus_control_unit: RTL and testbench
===================================

BUS_CONTROL_UNIT -- requirements
Module: bus_control_unit

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: maximum consecutive EU cycles granted while a prefetch is pending.
REQ-002 clk  input  1  sole clock; all state changes on posedge.
REQ-003 resetb  input  1  reset, asynchronous, active-low.
REQ-004 readyb  input  1  memory ready, active-low, sampled at posedge.
REQ-005 eu_bus_command  input  2  IDLE=0, READ=1, WRITE=2; held by the EU until eu_bus_done.
REQ-006 eu_bus_address  input  20  EU physical address.
REQ-007 eu_bus_word  input  1  1 = word access, 0 = byte access.
REQ-008 ps, pfp  input  16 each  program segment and prefetch pointer.
REQ-009 queue_full, queue_flush  input  1 each  queue cannot accept a word; branch or interrupt discards the queue.
REQ-010 address_out  output  20  registered bus address.
REQ-011 bus_status  output  4  1111 idle, 1001 read/fetch, 1010 write.
REQ-012 bus_word  output  1  registered width of the current cycle.
REQ-013 queue_push, queue_push_byte  output  1 each  one-cycle push pulse; push holds a single byte only.
REQ-014 eu_bus_done  output  1  one-cycle pulse when the EU transaction has fully completed.

Function
REQ-015 States SHALL be IDLE, FETCH, EU_RD, EU_WR and EU_RD2/EU_WR2 (second half of a split access).
REQ-016 In IDLE the block SHALL grant at most one cycle per clock: EU if eu_bus_command != IDLE, unless a prefetch is pending and the EU streak equals STARVE_LIMIT; else FETCH if !queue_full; else stay IDLE.
REQ-017 A prefetch is pending when !queue_full, and it SHALL NOT be granted during the same cycle as queue_flush.
REQ-018 On grant, address_out, bus_status and bus_word SHALL be registered and valid from the next cycle, held stable until readyb is sampled low.
REQ-019 FETCH address SHALL be {ps,4'h0}+{4'h0,pfp}, truncated to 20 bits; bus_word = !pfp[0]; queue_push_byte latched = pfp[0].
REQ-020 On readyb low in FETCH, the block SHALL pulse queue_push on the next cycle unless queue_flush was asserted at any point since grant, including the completion cycle.
REQ-021 An EU word access at an even address SHALL be one word cycle; at an odd address it SHALL be two byte cycles, at A then (A+1) mod 2^20, with no prefetch interleaved.
REQ-022 eu_bus_done SHALL pulse exactly once, in the cycle after the final readyb-low sample of the EU transaction.
REQ-023 After every completed bus cycle, the block SHALL spend exactly one cycle in IDLE with bus_status = 1111.
REQ-024 Wait states are unbounded: the block SHALL hold the current cycle while readyb is high.
REQ-025 The EU streak counter SHALL increment on each EU grant, saturate at STARVE_LIMIT, and clear on a FETCH grant or when no prefetch is pending.
REQ-026 A bus cycle in progress SHALL NOT be aborted by queue_flush or by EU command changes.

Reset
REQ-027 On resetb low, immediately and independent of clk: state=IDLE, bus_status=1111, address_out=20'hFFFFF, bus_word=0, queue_push=0, queue_push_byte=0, eu_bus_done=0, streak=0, pending flush flag=0.
REQ-028 Reset mid-cycle SHALL discard that transaction with no push and no done pulse; the first grant SHALL occur no earlier than the first posedge after resetb deasserts.

Structure
REQ-029 Bus command codes, bus_status constants and the state enum SHALL live in the shared package v30mz_pkg.
REQ-030 No sub-module is required; the 20-bit address adder SHALL be inline.

Verification
REQ-031 ps=FFFF, pfp=0000, readyb low after 2 waits -> address_out=FFFF0, status 1001, bus_word=1, one queue_push pulse, then one 1111 cycle.
REQ-032 pfp=0003 -> bus_word=0, queue_push_byte=1 on push.
REQ-033 EU READ word at 0x12345 -> byte cycles at 12345 then 12346, one eu_bus_done after the second, no FETCH between them.
REQ-034 EU WRITE held continuously with queue not full, STARVE_LIMIT=3 -> grant order EU,EU,EU,FETCH,EU; status 1010 on EU cycles.
REQ-035 queue_flush asserted mid-FETCH and in the readyb-low cycle -> cycle completes on bus, queue_push stays 0.
REQ-036 resetb low during EU_WR wait -> outputs at reset values immediately, no eu_bus_done pulse.

Source files
------------

// File: rtl/v30mz_pkg.sv
// ----------------------------------------------------------------------------
// v30mz_pkg
// Shared definitions for the V30MZ bus interface unit: EU bus command codes,
// bus_status encodings and the bus control state enumeration.
// ----------------------------------------------------------------------------
package v30mz_pkg;

    // EU bus command codes (eu_bus_command)
    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    // bus_status encodings
    localparam logic [3:0] STAT_IDLE  = 4'b1111;
    localparam logic [3:0] STAT_READ  = 4'b1001;  // EU read and code fetch
    localparam logic [3:0] STAT_WRITE = 4'b1010;

    localparam logic [19:0] ADDR_RESET = 20'hFFFFF;

    // *_RD2 / *_WR2 carry the second byte of a word access at an odd address.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EU_RD  = 3'd2,
        S_EU_WR  = 3'd3,
        S_EU_RD2 = 3'd4,
        S_EU_WR2 = 3'd5
    } bcu_state_e;

endpackage

// File: rtl/bus_control_unit_if.sv
// ----------------------------------------------------------------------------
// bus_control_unit_if
// Groups the bus control unit's handshake and bus signals.
//   master : bus control unit side (drives address/status/push/done)
//   slave  : environment side (memory ready, EU request, prefetch queue)
// Signals:
//   readyb            memory ready, active-low
//   eu_bus_command    EU request (IDLE/READ/WRITE), held until eu_bus_done
//   eu_bus_address    EU physical address
//   eu_bus_word       1 = word access, 0 = byte access
//   ps, pfp           program segment and prefetch pointer
//   queue_full        prefetch queue cannot accept a word
//   queue_flush       prefetch queue is being discarded
//   address_out       registered bus address
//   bus_status        1111 idle, 1001 read/fetch, 1010 write
//   bus_word          registered width of the current cycle
//   queue_push        one-cycle push pulse into the prefetch queue
//   queue_push_byte   qualifies queue_push: only one byte is valid
//   eu_bus_done       one-cycle pulse at EU transaction completion
// ----------------------------------------------------------------------------
interface bus_control_unit_if;

    logic        readyb;
    logic [1:0]  eu_bus_command;
    logic [19:0] eu_bus_address;
    logic        eu_bus_word;
    logic [15:0] ps;
    logic [15:0] pfp;
    logic        queue_full;
    logic        queue_flush;

    logic [19:0] address_out;
    logic [3:0]  bus_status;
    logic        bus_word;
    logic        queue_push;
    logic        queue_push_byte;
    logic        eu_bus_done;

    modport master (
        input  readyb, eu_bus_command, eu_bus_address, eu_bus_word,
               ps, pfp, queue_full, queue_flush,
        output address_out, bus_status, bus_word,
               queue_push, queue_push_byte, eu_bus_done
    );

    modport slave (
        output readyb, eu_bus_command, eu_bus_address, eu_bus_word,
               ps, pfp, queue_full, queue_flush,
        input  address_out, bus_status, bus_word,
               queue_push, queue_push_byte, eu_bus_done
    );

endinterface

// File: rtl/bus_control_unit.sv
// ----------------------------------------------------------------------------
// bus_control_unit
// Arbitrates the external bus between EU data accesses and code prefetch.
// One bus cycle is granted per IDLE clock; every completed cycle is followed
// by exactly one IDLE clock. Word accesses at odd addresses are split into
// two byte cycles (A, A+1) with no fetch in between. A streak counter stops
// the EU from starving the prefetcher for more than STARVE_LIMIT grants.
// Ports:
//   clk     sole clock, rising edge
//   resetb  asynchronous active-low reset
//   bus     bus_control_unit_if.master (see interface header)
// Parameters:
//   STARVE_LIMIT  max consecutive EU grants while a prefetch is pending
// ----------------------------------------------------------------------------
module bus_control_unit
    import v30mz_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic               clk,
    input  logic               resetb,
    bus_control_unit_if.master bus
);

    // +2 keeps the counter at least one bit wide even for STARVE_LIMIT == 0
    localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 2);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    bcu_state_e    state_q, state_d;
    logic [19:0]   addr_q, addr_d;
    logic [19:0]   addr2_q, addr2_d;     // address of the second half of a split
    logic [3:0]    status_q, status_d;
    logic          word_q, word_d;
    logic          push_q, push_d;
    logic          pbyte_q, pbyte_d;
    logic          done_q, done_d;
    logic          byte_q, byte_d;       // fetch at odd pfp yields one byte
    logic          flush_q, flush_d;     // flush seen since the fetch grant
    logic          split_q, split_d;     // second half of a split still owed
    logic          wr_q, wr_d;           // current EU transaction is a write
    logic [SW-1:0] streak_q, streak_d;

    logic        pending;
    logic        starved;
    logic        eu_req;
    logic        eu_wr;
    logic        beat_end;
    logic        grant_eu;
    logic        grant_fetch;
    logic        grant_split;
    logic [19:0] fetch_addr;

    assign pending    = !bus.queue_full;
    assign starved    = pending && (streak_q == STREAK_MAX);
    assign eu_req     = (bus.eu_bus_command != CMD_IDLE);
    assign eu_wr      = (bus.eu_bus_command == CMD_WRITE);
    assign beat_end   = (state_q != S_IDLE) && !bus.readyb;
    assign fetch_addr = {bus.ps, 4'h0} + {4'h0, bus.pfp};

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // ----------------------------------------------------------- next state
    // An owed split half outranks everything so the access stays atomic.
    always_comb begin
        grant_split = 1'b0;
        grant_eu    = 1'b0;
        grant_fetch = 1'b0;
        state_d     = state_q;
        case (state_q)
            S_IDLE: begin
                if (split_q) begin
                    grant_split = 1'b1;
                    state_d     = wr_q ? S_EU_WR2 : S_EU_RD2;
                end else if (eu_req && !starved) begin
                    grant_eu = 1'b1;
                    state_d  = eu_wr ? S_EU_WR : S_EU_RD;
                end else if (pending && !bus.queue_flush) begin
                    grant_fetch = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            // Bus cycles are never aborted; only memory ready ends them.
            default: if (!bus.readyb) state_d = S_IDLE;
        endcase
    end

    // --------------------------------------------------------------- output
    always_comb begin
        addr_d   = addr_q;
        addr2_d  = addr2_q;
        status_d = status_q;
        word_d   = word_q;
        push_d   = 1'b0;
        pbyte_d  = 1'b0;
        done_d   = 1'b0;
        byte_d   = byte_q;
        flush_d  = flush_q;
        split_d  = split_q;
        wr_d     = wr_q;
        streak_d = streak_q;

        if (grant_fetch) begin
            addr_d   = fetch_addr;
            status_d = STAT_READ;
            word_d   = !bus.pfp[0];
            byte_d   = bus.pfp[0];
            flush_d  = 1'b0;
            streak_d = '0;
        end

        if (grant_eu) begin
            wr_d     = eu_wr;
            status_d = eu_wr ? STAT_WRITE : STAT_READ;
            addr_d   = bus.eu_bus_address;
            addr2_d  = bus.eu_bus_address + 20'd1;
            split_d  = bus.eu_bus_word && bus.eu_bus_address[0];
            word_d   = bus.eu_bus_word && !bus.eu_bus_address[0];
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
        end

        if (grant_split) begin
            addr_d   = addr2_q;
            status_d = wr_q ? STAT_WRITE : STAT_READ;
            word_d   = 1'b0;
            split_d  = 1'b0;
        end

        // A flush anywhere in the fetch, including its last clock, drops the push.
        if (state_q == S_FETCH && bus.queue_flush) flush_d = 1'b1;

        if (beat_end) begin
            status_d = STAT_IDLE;
            if (state_q == S_FETCH) begin
                push_d  = !(flush_q || bus.queue_flush);
                pbyte_d = byte_q && !(flush_q || bus.queue_flush);
                flush_d = 1'b0;
            end else if (!split_q) begin
                done_d = 1'b1;
            end
        end

        if (!pending) streak_d = '0;
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            addr_q   <= ADDR_RESET;
            addr2_q  <= '0;
            status_q <= STAT_IDLE;
            word_q   <= 1'b0;
            push_q   <= 1'b0;
            pbyte_q  <= 1'b0;
            done_q   <= 1'b0;
            byte_q   <= 1'b0;
            flush_q  <= 1'b0;
            split_q  <= 1'b0;
            wr_q     <= 1'b0;
            streak_q <= '0;
        end else begin
            addr_q   <= addr_d;
            addr2_q  <= addr2_d;
            status_q <= status_d;
            word_q   <= word_d;
            push_q   <= push_d;
            pbyte_q  <= pbyte_d;
            done_q   <= done_d;
            byte_q   <= byte_d;
            flush_q  <= flush_d;
            split_q  <= split_d;
            wr_q     <= wr_d;
            streak_q <= streak_d;
        end
    end

    assign bus.address_out     = addr_q;
    assign bus.bus_status      = status_q;
    assign bus.bus_word        = word_q;
    assign bus.queue_push      = push_q;
    assign bus.queue_push_byte = pbyte_q;
    assign bus.eu_bus_done     = done_q;

endmodule

// File: tb/tb_bus_control_unit.sv
// ----------------------------------------------------------------------------
// tb_bus_control_unit
// Directed scenarios plus a randomized phase. A transaction-level reference
// model (queue of pending bus beats, streak count, flush flag) predicts every
// output each clock; inputs are driven on the falling edge and outputs are
// sampled on the following falling edge.
// ----------------------------------------------------------------------------
module tb_bus_control_unit;

    localparam int STARVE = 3;

    typedef struct packed {
        logic [19:0] a;
        logic [3:0]  st;
        logic        w;
    } beat_t;

    logic clk;
    logic resetb;

    bus_control_unit_if bif();

    bus_control_unit #(.STARVE_LIMIT(STARVE)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // reference model
    beat_t       beats[$];
    bit          m_busy, m_fetch, m_byte, m_flushed;
    int          m_streak;
    logic [19:0] e_addr;
    logic [3:0]  e_status;
    logic        e_word, e_push, e_pbyte, e_done;

    // stimulus control
    bit rnd_mode, eu_hold;
    int wait_n, wcnt;

    // observation of the DUT
    beat_t      dut_log[$];
    int         n_push, n_done;
    logic [3:0] prev_status;
    logic [3:0] exp34 [5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        beats.delete();
        m_busy = 0; m_fetch = 0; m_byte = 0; m_flushed = 0; m_streak = 0;
        e_addr = 20'hFFFFF; e_status = 4'hF; e_word = 0;
        e_push = 0; e_pbyte = 0; e_done = 0;
        wcnt = 0; prev_status = 4'hF;
    endtask

    task automatic start_beat(input beat_t b);
        e_addr = b.a; e_status = b.st; e_word = b.w;
        m_busy = 1; m_fetch = 0;
    endtask

    // Predict what the next rising edge does given the inputs now applied.
    task automatic model_step();
        bit          pend;
        beat_t       b;
        logic [3:0]  st;
        logic [19:0] fa;
        e_push = 0; e_pbyte = 0; e_done = 0;
        pend = !bif.queue_full;
        if (m_busy) begin
            if (m_fetch && bif.queue_flush) m_flushed = 1;
            if (!bif.readyb) begin
                m_busy = 0;
                e_status = 4'hF;
                if (m_fetch) begin
                    e_push  = !m_flushed;
                    e_pbyte = !m_flushed && m_byte;
                end else if (beats.size() == 0) begin
                    e_done = 1;
                end
            end
        end else if (beats.size() != 0) begin
            start_beat(beats.pop_front());
        end else if (bif.eu_bus_command != 2'd0 && !(pend && m_streak == STARVE)) begin
            st = (bif.eu_bus_command == 2'd2) ? 4'hA : 4'h9;
            if (bif.eu_bus_word && bif.eu_bus_address[0]) begin
                b.a = bif.eu_bus_address;         b.st = st; b.w = 0; beats.push_back(b);
                b.a = bif.eu_bus_address + 20'd1; b.st = st; b.w = 0; beats.push_back(b);
            end else begin
                b.a = bif.eu_bus_address; b.st = st; b.w = bif.eu_bus_word; beats.push_back(b);
            end
            start_beat(beats.pop_front());
            m_streak = (m_streak < STARVE) ? m_streak + 1 : STARVE;
        end else if (pend && !bif.queue_flush) begin
            fa = {bif.ps, 4'h0} + {4'h0, bif.pfp};
            e_addr = fa; e_status = 4'h9; e_word = !bif.pfp[0];
            m_byte = bif.pfp[0]; m_flushed = 0; m_fetch = 1; m_busy = 1;
            m_streak = 0;
        end
        if (!pend) m_streak = 0;
    endtask

    task automatic cyc();
        beat_t b;
        if (rnd_mode) begin
            bif.queue_full  = ($urandom_range(0, 3) == 0);
            bif.queue_flush = ($urandom_range(0, 5) == 0);
            bif.ps  = 16'($urandom);
            bif.pfp = 16'($urandom);
            if (bif.eu_bus_command == 2'd0) begin
                if ($urandom_range(0, 3) == 0) begin
                    bif.eu_bus_command = 2'($urandom_range(1, 2));
                    bif.eu_bus_address = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'($urandom);
                    bif.eu_bus_word    = 1'($urandom_range(0, 1));
                end
            end else if (e_done) begin
                bif.eu_bus_command = 2'd0;
            end
        end else if (e_done && !eu_hold) begin
            bif.eu_bus_command = 2'd0;
        end
        if (m_busy) begin
            wcnt++;
            bif.readyb = rnd_mode ? ($urandom_range(0, 2) != 0) : (wcnt <= wait_n);
        end else begin
            wcnt = 0;
            bif.readyb = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("addr",  32'(bif.address_out),     32'(e_addr));
        chk("stat",  32'(bif.bus_status),      32'(e_status));
        chk("word",  32'(bif.bus_word),        32'(e_word));
        chk("push",  32'(bif.queue_push),      32'(e_push));
        chk("pbyte", 32'(bif.queue_push_byte), 32'(e_pbyte));
        chk("done",  32'(bif.eu_bus_done),     32'(e_done));
        if (prev_status == 4'hF && bif.bus_status != 4'hF) begin
            b.a = bif.address_out; b.st = bif.bus_status; b.w = bif.bus_word;
            dut_log.push_back(b);
        end
        prev_status = bif.bus_status;
        n_push += int'(bif.queue_push);
        n_done += int'(bif.eu_bus_done);
    endtask

    task automatic clear_obs();
        dut_log.delete();
        n_push = 0;
        n_done = 0;
    endtask

    // Let any transaction finish, then leave the block idle.
    task automatic drain();
        int k;
        rnd_mode = 0; eu_hold = 0; wait_n = 1;
        bif.queue_full = 1; bif.queue_flush = 0;
        k = 0;
        while ((m_busy || beats.size() != 0 || bif.eu_bus_command != 2'd0) && k < 200) begin
            cyc();
            k++;
        end
        chk("drain_in_bound", 32'(k < 200), 32'd1);
        cyc();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr"},  32'(bif.address_out),     32'hFFFFF);
        chk({tag, "_stat"},  32'(bif.bus_status),      32'hF);
        chk({tag, "_word"},  32'(bif.bus_word),        32'd0);
        chk({tag, "_push"},  32'(bif.queue_push),      32'd0);
        chk({tag, "_pbyte"}, 32'(bif.queue_push_byte), 32'd0);
        chk({tag, "_done"},  32'(bif.eu_bus_done),     32'd0);
    endtask

    task automatic fetch_flush(input string tag, input bit fl_mid, input bit fl_last,
                               input int exp_push);
        drain();
        clear_obs();
        bif.ps = 16'h1000; bif.pfp = 16'h0010; bif.queue_full = 0; wait_n = 3;
        cyc();
        chk({tag, "_addr"}, 32'(bif.address_out), 32'h10010);
        chk({tag, "_stat"}, 32'(bif.bus_status),  32'h9);
        bif.queue_full = 1;
        for (int i = 1; i <= 4; i++) begin
            bif.queue_flush = (i == 2 && fl_mid) || (i == 4 && fl_last);
            cyc();
        end
        bif.queue_flush = 0;
        chk({tag, "_end"}, 32'(bif.bus_status), 32'hF);
        cyc();
        chk({tag, "_npush"}, 32'(n_push), 32'(exp_push));
    endtask

    initial begin
        int k;
        n_tests = 0; n_fail = 0;
        exp34[0] = 4'hA; exp34[1] = 4'hA; exp34[2] = 4'hA; exp34[3] = 4'h9; exp34[4] = 4'hA;
        rnd_mode = 0; eu_hold = 0; wait_n = 0;
        resetb = 1'b0;
        bif.readyb = 1; bif.eu_bus_command = 2'd0; bif.eu_bus_address = '0;
        bif.eu_bus_word = 0; bif.ps = '0; bif.pfp = '0;
        bif.queue_full = 1; bif.queue_flush = 0;
        model_reset();
        clear_obs();
        repeat (2) @(negedge clk);
        check_reset("rst");
        resetb = 1'b1;
        cyc();

        // fetch at top of memory: FFFF0, word, one push, one idle clock
        clear_obs();
        bif.ps = 16'hFFFF; bif.pfp = 16'h0000; bif.queue_full = 0; wait_n = 2;
        cyc();
        chk("r31_addr", 32'(bif.address_out), 32'hFFFF0);
        chk("r31_stat", 32'(bif.bus_status),  32'h9);
        chk("r31_word", 32'(bif.bus_word),    32'd1);
        bif.queue_full = 1;
        repeat (3) cyc();
        chk("r31_idle",  32'(bif.bus_status), 32'hF);
        chk("r31_push",  32'(bif.queue_push), 32'd1);
        chk("r31_npush", 32'(n_push),         32'd1);
        bif.queue_full = 0;
        cyc();
        chk("r31_regrant", 32'(bif.bus_status), 32'h9);

        // fetch at odd pfp: byte cycle, byte push
        drain();
        clear_obs();
        bif.ps = 16'h0000; bif.pfp = 16'h0003; bif.queue_full = 0; wait_n = 0;
        cyc();
        chk("r32_addr", 32'(bif.address_out), 32'h00003);
        chk("r32_word", 32'(bif.bus_word),    32'd0);
        bif.queue_full = 1;
        cyc();
        chk("r32_push",  32'(bif.queue_push),      32'd1);
        chk("r32_pbyte", 32'(bif.queue_push_byte), 32'd1);

        // odd word read split into two byte cycles, one done
        drain();
        clear_obs();
        bif.queue_full = 0; wait_n = 1;
        bif.eu_bus_command = 2'd1; bif.eu_bus_address = 20'h12345; bif.eu_bus_word = 1;
        k = 0;
        while (n_done == 0 && k < 40) begin cyc(); k++; end
        chk("r33_done_seen", 32'(n_done),         32'd1);
        chk("r33_ncycles",   32'(dut_log.size()), 32'd2);
        if (dut_log.size() >= 2) begin
            chk("r33_a0", 32'(dut_log[0].a),  32'h12345);
            chk("r33_a1", 32'(dut_log[1].a),  32'h12346);
            chk("r33_s1", 32'(dut_log[1].st), 32'h9);
            chk("r33_w1", 32'(dut_log[1].w),  32'd0);
        end
        repeat (3) cyc();
        chk("r33_done_once", 32'(n_done), 32'd1);

        // held EU write vs pending prefetch: EU,EU,EU,FETCH,EU
        drain();
        clear_obs();
        bif.queue_full = 0; wait_n = 0; eu_hold = 1;
        bif.eu_bus_command = 2'd2; bif.eu_bus_address = 20'h00100; bif.eu_bus_word = 1;
        k = 0;
        while (dut_log.size() < 5 && k < 60) begin cyc(); k++; end
        chk("r34_ngrant", 32'(dut_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < dut_log.size(); i++)
            chk($sformatf("r34_grant%0d", i), 32'(dut_log[i].st), 32'(exp34[i]));
        eu_hold = 0;

        // flush during a fetch suppresses the push; the cycle still completes
        fetch_flush("r35_mid_last", 1, 1, 0);
        fetch_flush("r35_last",     0, 1, 0);
        fetch_flush("r35_none",     0, 0, 1);

        // reset during an EU write wait
        drain();
        clear_obs();
        bif.queue_full = 1; wait_n = 1000;
        bif.eu_bus_command = 2'd2; bif.eu_bus_address = 20'h00200; bif.eu_bus_word = 1;
        cyc();
        chk("r36_stat", 32'(bif.bus_status), 32'hA);
        cyc();
        cyc();
        #2 resetb = 1'b0;
        #1 check_reset("r36");
        model_reset();
        bif.eu_bus_command = 2'd0;
        bif.readyb = 0;
        @(posedge clk);
        @(negedge clk);
        chk("r36_done_held", 32'(bif.eu_bus_done), 32'd0);
        chk("r36_stat_held", 32'(bif.bus_status),  32'hF);
        resetb = 1'b1;
        cyc();
        chk("r36_ndone", 32'(n_done), 32'd0);

        // randomized traffic against the model
        drain();
        rnd_mode = 1;
        repeat (600) cyc();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
